// File: rtl/v1_trap_sequencer.sv
// v1_trap_sequencer: run controller for the trapezoidal shaping filter.
// It drives the filter reset and flushes the delay line before each
// acquisition. It triggers on the shaped output and samples the amplitude
// mid flat-top. It flags pile-up and presents each event on a
// valid/ready output slot.
// Ports:
//   clk, reset (sync, active-low)    clock and reset
//   cfg_enable, cfg_threshold        run control and signed trigger level
//   flt_data                         signed filter output, one sample per clk
//   flt_reset_n                      active-low reset driven to the filter
//   evt_valid/evt_ready              event handshake
//   evt_amp, evt_time, evt_pileup    event payload
//   busy                             in FLUSH, RISE or TAIL
//   drop_cnt                         saturating count of events lost to a full slot
module v1_trap_sequencer #(
  parameter int FLT_W    = 16,
  parameter int K        = 10,
  parameter int L        = 20,
  parameter int PEAK_DLY = 15,
  parameter int TS_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic [FLT_W-1:0] cfg_threshold,
  input  logic [FLT_W-1:0] flt_data,
  output logic             flt_reset_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [FLT_W-1:0] evt_amp,
  output logic [TS_W-1:0]  evt_time,
  output logic             evt_pileup,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int FLUSH_LEN = K + L + 2;
  localparam int CW        = $clog2(FLUSH_LEN + 1);
  localparam int TAIL_LEN  = K + L - PEAK_DLY;

  typedef enum logic [2:0] {IDLE, FLUSH, ARMED, RISE, TAIL} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [TS_W-1:0]  ts_cnt;
  logic [TS_W-1:0]  ts;
  logic [FLT_W-1:0] thr_lat;
  logic [FLT_W-1:0] amp;
  logic             pu;
  logic             prev_above;

  logic             above;
  logic             crossing;
  logic             tail_over;
  logic             pu_nxt;
  logic             win_end;
  logic             load;
  logic [FLT_W:0]   amp_thr;

  // Trigger / re-crossing comparison against the threshold latched at arm time.
  assign above    = $signed(flt_data) > $signed(thr_lat);
  assign crossing = above && !prev_above;

  // Amplitude plus threshold is formed one bit wider so it cannot wrap.
  assign amp_thr   = $signed({amp[FLT_W-1], amp}) + $signed({thr_lat[FLT_W-1], thr_lat});
  assign tail_over = (state == TAIL) &&
                     ($signed({flt_data[FLT_W-1], flt_data}) > $signed(amp_thr));

  // Includes the current sample so the last window cycle still counts.
  assign pu_nxt  = pu | (((state == RISE) || (state == TAIL)) && crossing) | tail_over;
  assign win_end = (state == TAIL) && (cnt == CW'(TAIL_LEN - 1));
  assign load    = win_end && cfg_enable;

  always_comb begin
    state_nxt   = state;
    flt_reset_n = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (cnt == CW'(FLUSH_LEN - 1)) state_nxt = ARMED;
      end
      ARMED: begin
        flt_reset_n = 1'b1;
        if (above) state_nxt = RISE;
      end
      RISE: begin
        flt_reset_n = 1'b1;
        busy        = 1'b1;
        if (cnt == CW'(PEAK_DLY - 1)) state_nxt = TAIL;
      end
      TAIL: begin
        flt_reset_n = 1'b1;
        busy        = 1'b1;
        if (win_end) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
    // Disabling aborts from any state; the output slot is left alone.
    if (!cfg_enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ts_cnt     <= '0;
      ts         <= '0;
      thr_lat    <= '0;
      amp        <= '0;
      pu         <= 1'b0;
      prev_above <= 1'b0;
      evt_valid  <= 1'b0;
      evt_amp    <= '0;
      evt_time   <= '0;
      evt_pileup <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      ts_cnt <= ts_cnt + 1'b1;

      // cnt restarts on every state entry and only runs in timed states.
      if (state_nxt != state)
        cnt <= '0;
      else if ((state == FLUSH) || (state == RISE) || (state == TAIL))
        cnt <= cnt + 1'b1;

      if ((state == FLUSH) && (state_nxt == ARMED))
        thr_lat <= cfg_threshold;

      if ((state == ARMED) && (state_nxt == RISE)) begin
        ts         <= ts_cnt;
        pu         <= 1'b0;
        prev_above <= 1'b1;
      end

      if ((state == RISE) || (state == TAIL)) begin
        prev_above <= above;
        pu         <= pu_nxt;
      end

      if ((state == RISE) && (cnt == CW'(PEAK_DLY - 1)))
        amp <= flt_data;

      // Output slot: a load may fall through an accept in the same cycle.
      if (load) begin
        if (!evt_valid || evt_ready) begin
          evt_valid  <= 1'b1;
          evt_amp    <= amp;
          evt_time   <= ts;
          evt_pileup <= pu_nxt;
        end else if (drop_cnt != {CNT_W{1'b1}}) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_v1_trap_sequencer.sv
// Bench for v1_trap_sequencer: time-based reference model checked every
// cycle, plus literal expectations for flush length, latency, amplitude,
// pile-up, backpressure, fall-through load, abort and threshold latching.
module tb_v1_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_threshold = '0;
  logic [15:0] flt_data = '0;
  logic        flt_reset_n;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [15:0] evt_amp;
  logic [31:0] evt_time;
  logic        evt_pileup;
  logic        busy;
  logic [15:0] drop_cnt;

  v1_trap_sequencer dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold),
    .flt_data(flt_data), .flt_reset_n(flt_reset_n), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_amp(evt_amp), .evt_time(evt_time),
    .evt_pileup(evt_pileup), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Edge counter aligned with the DUT timestamp (timestamp = cyc - 1 at an edge).
  int cyc = 0;
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // ---------------- reference model (absolute edge times) ----------------
  bit          m_live = 0;
  int          m_e, m_trig, m_arm_at, m_thr, m_amp, m_k, m_d;
  bit          m_phase, m_pu, m_prev, m_above, m_load;
  logic [31:0] m_tick, m_ts;
  bit          e_valid, e_pu, e_frn, e_busy, e_armed;
  int          e_amp, e_drop;
  logic [31:0] e_time;

  always @(posedge clk) begin
    if (!reset) begin
      m_live = 1; m_e = 0; m_tick = 0; m_phase = 0; m_trig = -1; m_arm_at = 0;
      m_thr = 0; m_amp = 0; m_pu = 0; m_prev = 0;
      e_valid = 0; e_drop = 0; e_frn = 0; e_busy = 0;
    end else begin
      m_d = int'($signed(flt_data));
      m_load = 0;
      m_e++;
      if (!cfg_enable) begin
        m_phase = 0; m_trig = -1;
      end else if (!m_phase) begin
        m_phase = 1; m_arm_at = m_e + 33;
      end else begin
        if (m_e == m_arm_at - 1) m_thr = int'($signed(cfg_threshold));
        if (m_trig < 0) begin
          if (m_e >= m_arm_at && m_d > m_thr) begin
            m_trig = m_e; m_ts = m_tick; m_pu = 0; m_prev = 1;
          end
        end else begin
          m_k = m_e - m_trig;
          m_above = (m_d > m_thr);
          if (m_above && !m_prev) m_pu = 1;
          m_prev = m_above;
          if (m_k == 15) m_amp = m_d;
          if (m_k > 15 && m_d > m_amp + m_thr) m_pu = 1;
          if (m_k == 30) begin
            m_load = 1; m_trig = -1; m_arm_at = m_e + 33;
          end
        end
      end
      if (m_load) begin
        if (!e_valid || evt_ready) begin
          e_valid = 1; e_amp = m_amp; e_time = m_ts; e_pu = m_pu;
        end else if (e_drop < 65535) e_drop++;
      end else if (e_valid && evt_ready) e_valid = 0;
      m_tick = m_tick + 1;
      e_armed = m_phase && (m_trig < 0) && (m_e >= m_arm_at - 1);
      e_frn   = e_armed || (m_trig >= 0);
      e_busy  = m_phase && !e_armed;
    end
  end

  always @(negedge clk) begin
    if (m_live && reset) begin
      chk("evt_valid", evt_valid, e_valid);
      chk("flt_reset_n", flt_reset_n, e_frn);
      chk("busy", busy, e_busy);
      chk("drop_cnt", drop_cnt, e_drop);
      if (e_valid) begin
        chk("evt_amp", $signed(evt_amp), e_amp);
        chk("evt_time", evt_time, e_time);
        chk("evt_pileup", evt_pileup, e_pu);
      end
    end
  end

  // ---------------- event monitor ----------------
  int          n_acc = 0, rise_cyc = -1, last_amp = 0, last_pu = 0;
  longint      last_time = 0;
  bit          valid_d = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (evt_valid && !valid_d) rise_cyc = cyc;
      if (evt_valid && evt_ready) begin
        n_acc++; last_amp = int'($signed(evt_amp)); last_pu = evt_pileup; last_time = evt_time;
      end
      valid_d = evt_valid;
    end
  end

  // ---------------- stimulus ----------------
  int trig_cyc;

  function automatic int shape(input int kind, input int j);
    int v;
    if (j <= 10) v = 100 * j;
    else if (j <= 20) v = 1000;
    else if (j <= 30) v = 1000 - 100 * (j - 20);
    else v = 0;
    if (kind == 1) begin
      if (j == 18 || j == 19) v = 50;
      else if (j >= 20 && j <= 25) v = 800;
      else if (j > 25) v = 0;
    end
    if (kind == 2 && j == 20) v = 1200;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      flt_data = '0;
    end
  endtask

  // ready_pulse: evt_ready high only for the load edge; abort_at/thr_at: offsets after trigger
  task automatic pulse(input int kind, input bit ready_pulse, input int abort_at, input int thr_at);
    int v, cap;
    trig_cyc = -1;
    for (int j = 0; j < 40; j++) begin
      step();
      v = shape(kind, j);
      flt_data = 16'(v);
      cap = cyc + 1;
      if (trig_cyc < 0 && v > 100) trig_cyc = cap;
      if (ready_pulse) evt_ready = (trig_cyc >= 0) && (cap == trig_cyc + 30);
      if (abort_at > 0 && trig_cyc >= 0 && cap == trig_cyc + abort_at) cfg_enable = 1'b0;
      if (thr_at > 0 && trig_cyc >= 0 && cap == trig_cyc + thr_at) cfg_threshold = 16'd2000;
    end
  endtask

  int lowc, acc0, tA, tB;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_frn", flt_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_amp", evt_amp, 0);
    chk("rst_time", evt_time, 0);

    step();
    reset = 1'b1; cfg_enable = 1'b1; cfg_threshold = 16'd100; evt_ready = 1'b1;
    lowc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !flt_reset_n) lowc++;
      if (flt_reset_n) break;
    end
    chk("flush_len", lowc, 32);
    chk("armed_frn", flt_reset_n, 1);
    chk("armed_busy", busy, 0);

    // single trapezoid
    pulse(0, 0, 0, 0); idle(40);
    chk("single_n", n_acc, 1);
    chk("single_amp", last_amp, 1000);
    chk("single_pu", last_pu, 0);
    chk("single_time", last_time, trig_cyc - 1);
    chk("single_lat", rise_cyc - trig_cyc, 30);

    // second crossing, then tail overshoot
    pulse(1, 0, 0, 0); idle(40);
    chk("xing_amp", last_amp, 1000);
    chk("xing_pu", last_pu, 1);
    pulse(2, 0, 0, 0); idle(40);
    chk("over_amp", last_amp, 1000);
    chk("over_pu", last_pu, 1);
    chk("acc3", n_acc, 3);

    // backpressure across two events
    evt_ready = 1'b0;
    pulse(0, 0, 0, 0); tA = trig_cyc; idle(40);
    pulse(0, 0, 0, 0); idle(40);
    @(negedge clk);
    chk("bp_drop", drop_cnt, 1);
    chk("bp_valid", evt_valid, 1);
    chk("bp_time", evt_time, tA - 1);
    step(); evt_ready = 1'b1;
    step(); evt_ready = 1'b0;
    @(negedge clk);
    chk("bp_fall", evt_valid, 0);
    chk("bp_acc_time", last_time, tA - 1);

    // accept coinciding with the next load: no drop, new event follows
    pulse(0, 0, 0, 0); idle(40);
    pulse(0, 1, 0, 0); tB = trig_cyc; idle(5);
    @(negedge clk);
    chk("sim_valid", evt_valid, 1);
    chk("sim_time", evt_time, tB - 1);
    chk("sim_drop", drop_cnt, 1);
    evt_ready = 1'b1; idle(40);

    // abort at T+5
    acc0 = n_acc;
    pulse(0, 0, 5, 0); idle(10);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_frn", flt_reset_n, 0);
    chk("abort_n", n_acc, acc0);
    chk("abort_drop", drop_cnt, 1);
    cfg_enable = 1'b1; idle(40);

    // threshold change mid-event takes effect only at the next arm
    acc0 = n_acc;
    pulse(2, 0, 0, 5); idle(40);
    chk("thr_n", n_acc, acc0 + 1);
    chk("thr_pu", last_pu, 1);
    pulse(0, 0, 0, 0); idle(40);
    @(negedge clk);
    chk("thr_notrig", n_acc, acc0 + 1);
    chk("thr_armed", flt_reset_n, 1);
    chk("thr_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
